down_counter_timer: RTL and testbench

//  Loadable synchronous down-counter/timer; counts the other direction from the ripple up-counter.

---
 rtl/down_counter_timer.sv | 127 ++++++++++++
 tb/tb_down_counter_timer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable synchronous down-counter/timer with terminal-count pulse, pause/resume
// and optional auto-reload for periodic operation.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] reload_r;
    logic             tc_r;
    logic             busy_r;
    logic             paused_r;
    logic             done_r;

    // Status flags {busy, paused, done} for a given state; all zero in IDLE.
    function automatic logic [2:0] flags_f(input state_t st);
        logic [2:0] f;
        case (st)
            ST_RUN:  f = 3'b100;
            ST_HOLD: f = 3'b010;
            ST_DONE: f = 3'b001;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    // Control FSM, counter, reload register and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            q_r      <= ZERO_C;
            reload_r <= ZERO_C;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
            paused_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (clear) begin
                state_r                     <= ST_IDLE;
                q_r                         <= ZERO_C;
                {busy_r, paused_r, done_r}  <= flags_f(ST_IDLE);
            end else if (load) begin
                reload_r <= load_val;
                q_r      <= load_val;
            end else if (stop) begin
                if (state_r == ST_RUN) begin
                    state_r                    <= ST_HOLD;
                    {busy_r, paused_r, done_r} <= flags_f(ST_HOLD);
                end else begin
                    state_r <= state_r;
                end
            end else if (start && (state_r != ST_RUN)) begin
                case (state_r)
                    ST_HOLD: begin
                        state_r                    <= ST_RUN;
                        {busy_r, paused_r, done_r} <= flags_f(ST_RUN);
                    end
                    ST_IDLE, ST_DONE: begin
                        // A zero reload value terminates immediately.
                        q_r <= reload_r;
                        if (reload_r == ZERO_C) begin
                            state_r                    <= ST_DONE;
                            tc_r                       <= 1'b1;
                            {busy_r, paused_r, done_r} <= flags_f(ST_DONE);
                        end else begin
                            state_r                    <= ST_RUN;
                            {busy_r, paused_r, done_r} <= flags_f(ST_RUN);
                        end
                    end
                    default: begin
                        state_r                    <= ST_IDLE;
                        {busy_r, paused_r, done_r} <= flags_f(ST_IDLE);
                    end
                endcase
            end else if (tick && (state_r == ST_RUN)) begin
                // q of 0 (loaded mid-run) is treated as terminal so it never wraps.
                if (q_r > ONE_C) begin
                    q_r <= q_r - ONE_C;
                end else begin
                    tc_r <= 1'b1;
                    if (auto_reload) begin
                        q_r <= reload_r;
                    end else begin
                        q_r                        <= ZERO_C;
                        state_r                    <= ST_DONE;
                        {busy_r, paused_r, done_r} <= flags_f(ST_DONE);
                    end
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign q      = q_r;
    assign tc     = tc_r;
    assign busy   = busy_r;
    assign paused = paused_r;
    assign done   = done_r;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear, load, start, stop, tick, auto_reload;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, busy, paused, done;

    int n_tests = 0;
    int n_fail  = 0;
    int tc_cnt;

    down_counter_timer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .tick(tick), .auto_reload(auto_reload),
        .q(q), .tc(tc), .busy(busy), .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full state check: q, tc, and {busy,paused,done}.
    task automatic chk_all(input string tag, input int eq, input int etc, input int eflags);
        chk({tag, ".q"}, int'(q), eq);
        chk({tag, ".tc"}, int'(tc), etc);
        chk({tag, ".flags"}, int'({busy, paused, done}), eflags);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    localparam int IDLE_F = 0, RUN_F = 4, HOLD_F = 2, DONE_F = 1;

    int exp3 [9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        tick = 1'b0; auto_reload = 1'b0; load_val = 4'd0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk_all("reset_state", 0, 0, IDLE_F);

        // 1: reset mid-run clears everything immediately
        load = 1'b1; load_val = 4'd5; cyc();
        start = 1'b1; cyc();
        chk_all("t1_run", 5, 0, RUN_F);
        reset = 1'b1; #1;
        chk_all("t1_async_reset", 0, 0, IDLE_F);
        cyc();
        reset = 1'b0;
        tick = 1'b1; cyc(); tick = 1'b1; cyc();
        chk_all("t1_tick_ignored", 0, 0, IDLE_F);

        // 2: one-shot count 4..0
        load = 1'b1; load_val = 4'd4; cyc();
        chk_all("t2_load_idle", 4, 0, IDLE_F);
        start = 1'b1; cyc();
        chk_all("t2_start", 4, 0, RUN_F);
        for (int i = 3; i >= 1; i--) begin
            tick = 1'b1; cyc();
            chk_all("t2_tick", i, 0, RUN_F);
        end
        tick = 1'b1; cyc();
        chk_all("t2_terminal", 0, 1, DONE_F);
        cyc();
        chk_all("t2_done_hold", 0, 0, DONE_F);

        // 3: auto-reload periodic
        auto_reload = 1'b1;
        load = 1'b1; load_val = 4'd3; cyc();
        start = 1'b1; cyc();
        chk_all("t3_start", 3, 0, RUN_F);
        tc_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick = 1'b1; cyc();
            chk("t3_q", int'(q), exp3[i]);
            chk("t3_tc", int'(tc), (exp3[i] == 3) ? 1 : 0);
            tc_cnt += int'(tc);
        end
        chk("t3_tc_count", tc_cnt, 3);
        chk("t3_still_busy", int'(busy), 1);
        auto_reload = 1'b0;
        clear = 1'b1; cyc();
        chk_all("t3_clear", 0, 0, IDLE_F);

        // 4: pause and resume
        load = 1'b1; load_val = 4'd6; cyc();
        start = 1'b1; cyc();
        tick = 1'b1; cyc(); tick = 1'b1; cyc();
        chk_all("t4_two_ticks", 4, 0, RUN_F);
        stop = 1'b1; tick = 1'b1; cyc();
        chk_all("t4_stop", 4, 0, HOLD_F);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; cyc();
        end
        chk_all("t4_hold_frozen", 4, 0, HOLD_F);
        start = 1'b1; cyc();
        chk_all("t4_resume", 4, 0, RUN_F);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; cyc();
        end
        chk_all("t4_q1", 1, 0, RUN_F);
        tick = 1'b1; cyc();
        chk_all("t4_end", 0, 1, DONE_F);

        // 5: load beats tick; clear beats start
        load = 1'b1; load_val = 4'd3; cyc();
        start = 1'b1; cyc();
        tick = 1'b1; cyc();
        chk_all("t5_q2", 2, 0, RUN_F);
        load = 1'b1; load_val = 4'd9; tick = 1'b1; cyc();
        chk_all("t5_load_tick", 9, 0, RUN_F);
        clear = 1'b1; start = 1'b1; cyc();
        chk_all("t5_clear_start", 0, 0, IDLE_F);
        start = 1'b1; cyc();
        chk_all("t5_reload_kept", 9, 0, RUN_F);
        start = 1'b1; tick = 1'b1; cyc();
        chk_all("t5_start_in_run", 8, 0, RUN_F);

        // 6: zero reload and max reload
        load = 1'b1; load_val = 4'd0; cyc();
        chk_all("t6_load0", 0, 0, RUN_F);
        clear = 1'b1; cyc();
        start = 1'b1; cyc();
        chk_all("t6_zero_start", 0, 1, DONE_F);
        cyc();
        chk_all("t6_zero_after", 0, 0, DONE_F);
        load = 1'b1; load_val = 4'd15; cyc();
        start = 1'b1; cyc();
        chk_all("t6_max_start", 15, 0, RUN_F);
        for (int i = 0; i < 14; i++) begin
            tick = 1'b1; cyc();
        end
        chk_all("t6_max_14", 1, 0, RUN_F);
        tick = 1'b1; cyc();
        chk_all("t6_max_15", 0, 1, DONE_F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
